mem_access_unit: RTL and testbench

- Load/store front end for the data storage array in the RV32I multicycle pipeline.
- Accepts one byte-addressed request at a time from the memory stage.
- Drives one reader port and the single write port of the storage block, which indexes 32-bit word rows with one-cycle registered read latency.
- Performs byte/half extraction with sign/zero extension for loads, and read-modify-write for sub-word stores.

---
 rtl/memacc_pkg.sv | 23 ++
 rtl/mem_lane_align.sv | 41 ++++
 rtl/mem_access_unit.sv | 111 +++++++++++
 tb/tb_mem_access_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memacc_pkg.sv
// Shared definitions for the RV32I load/store front end: funct3 codes,
// FSM state encoding and the illegal-funct3 decode.
package memacc_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_RD_ISSUE   = 3'd1;
  localparam logic [2:0] ST_RD_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WRITE      = 3'd3;
  localparam logic [2:0] ST_RESP       = 3'd4;

  // Stores only have B/H/W; loads additionally have BU/HU.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 > F3_W);
    return (f3 == 3'd3) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: formats a load from a 32-bit row and merges
// sub-word store data into a row. Half/word lanes ignore the low address bits.
module mem_lane_align
  import memacc_pkg::*;
(
  input  logic [31:0] row,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_row
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;

  assign byte_sh  = {addr, 3'b000};
  assign half_sh  = {addr[1], 4'b0000};
  assign byte_val = 8'(row >> byte_sh);
  assign half_val = 16'(row >> half_sh);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    load_val  = row;
    store_row = row;
    case (funct3[1:0])
      2'b00: begin
        load_val  = funct3[2] ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
        store_row = (row & ~(32'h0000_00FF << byte_sh)) | ({24'b0, wdata[7:0]} << byte_sh);
      end
      2'b01: begin
        load_val  = funct3[2] ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
        store_row = (row & ~(32'h0000_FFFF << half_sh)) | ({16'b0, wdata} << half_sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the 32-bit-row data storage (1-cycle read latency).
// Optional MEMACC_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors.
module mem_access_unit
  import memacc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [2:0]        reqFunct3,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWData,
  output logic              respValid,
  output logic [DATA_W-1:0] respData,
  output logic              respErr,
  output logic [ADDR_W-1:0] memReadAddr,
  output logic              memReadEn,
  input  logic [DATA_W-1:0] memReadData,
  output logic [ADDR_W-1:0] memWriteAddr,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWriteEn
);

  logic [2:0]        state;
  logic              write_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [DATA_W-1:0] wrow_q;
  logic              req_err;
  logic [31:0]       load_val;
  logic [31:0]       store_row;

`ifdef MEMACC_MISALIGN_TRAP_EN
  assign req_err = f3_illegal(reqWrite, reqFunct3)
                 || ((reqFunct3[1:0] == 2'b01) && reqAddr[0])
                 || ((reqFunct3[1:0] == 2'b10) && (reqAddr[1:0] != 2'b00));
`else
  assign req_err = f3_illegal(reqWrite, reqFunct3);
`endif

  mem_lane_align u_align (
    .row       (memReadData),
    .addr      (addr_q[1:0]),
    .funct3    (f3_q),
    .wdata     (wdata_q),
    .load_val  (load_val),
    .store_row (store_row)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      write_q     <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      wrow_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (reqValid) begin
          write_q     <= reqWrite;
          f3_q        <= reqFunct3;
          addr_q      <= reqAddr;
          wdata_q     <= reqWData[15:0];
          err_q       <= req_err;
          resp_data_q <= '0;
          wrow_q      <= reqWData;
          if (req_err)
            state <= ST_RESP;
          else if (reqWrite && reqFunct3 == F3_W)
            state <= ST_WRITE;
          else
            state <= ST_RD_ISSUE;
        end
        ST_RD_ISSUE: state <= ST_RD_CAPTURE;
        ST_RD_CAPTURE: begin
          if (write_q) begin
            wrow_q <= store_row;
            state  <= ST_WRITE;
          end else begin
            resp_data_q <= load_val;
            state       <= ST_RESP;
          end
        end
        ST_WRITE: state <= ST_RESP;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign reqReady     = (state == ST_IDLE);
  assign memReadEn    = (state == ST_RD_ISSUE);
  assign memWriteEn   = (state == ST_WRITE);
  assign respValid    = (state == ST_RESP);
  assign respErr      = respValid && err_q;
  assign respData     = resp_data_q;
  assign memReadAddr  = {2'b00, addr_q[ADDR_W-1:2]};
  assign memWriteAddr = {2'b00, addr_q[ADDR_W-1:2]};
  assign memWriteData = wrow_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan cases, reset abort
// of an RMW, and randomized traffic against a byte-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqReady, reqWrite;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr, reqWData;
  logic        respValid, respErr;
  logic [31:0] respData;
  logic [31:0] memReadAddr, memReadData, memWriteAddr, memWriteData;
  logic        memReadEn, memWriteEn;

  int pass_cnt = 0;
  int total    = 0;

  logic [31:0] stor    [16];
  logic [31:0] ref_mem [16];

  typedef struct {
    int          rd_cyc, wr_cyc, resp_cyc, wr_cnt;
    logic [31:0] rd_addr, wr_addr, wr_data, rdata;
    logic        rerr, ready_idle, ready_busy;
  } obs_t;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqFunct3(reqFunct3), .reqAddr(reqAddr), .reqWData(reqWData),
    .respValid(respValid), .respData(respData), .respErr(respErr),
    .memReadAddr(memReadAddr), .memReadEn(memReadEn), .memReadData(memReadData),
    .memWriteAddr(memWriteAddr), .memWriteData(memWriteData), .memWriteEn(memWriteEn)
  );

  // Storage block stand-in: registered read, synchronous write.
  always @(posedge clk) begin
    if (memReadEn)  memReadData <= stor[memReadAddr[3:0]];
    if (memWriteEn) stor[memWriteAddr[3:0]] <= memWriteData;
  end

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output obs_t o);
    o.rd_cyc = 0; o.wr_cyc = 0; o.resp_cyc = 0; o.wr_cnt = 0;
    o.rd_addr = 0; o.wr_addr = 0; o.wr_data = 0; o.rdata = 0;
    o.rerr = 0; o.ready_busy = 0;
    @(negedge clk);
    o.ready_idle = reqReady;
    reqValid = 1'b1; reqWrite = w; reqFunct3 = f3; reqAddr = a; reqWData = wd;
    @(posedge clk);
    for (int k = 1; k <= 8 && o.resp_cyc == 0; k++) begin
      @(negedge clk);
      reqValid = 1'b0;
      if (k == 1) o.ready_busy = reqReady;
      if (memReadEn && o.rd_cyc == 0) begin o.rd_cyc = k; o.rd_addr = memReadAddr; end
      if (memWriteEn) begin
        o.wr_cnt++;
        if (o.wr_cyc == 0) begin o.wr_cyc = k; o.wr_addr = memWriteAddr; o.wr_data = memWriteData; end
      end
      if (respValid) begin o.resp_cyc = k; o.rdata = respData; o.rerr = respErr; end
    end
  endtask

  // Reference: plain byte arithmetic on the addressed row.
  function automatic logic ref_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
    logic e;
    e = w ? (f3 >= 3) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MEMACC_MISALIGN_TRAP_EN
    if (f3 % 4 == 1 && a % 2 != 0) e = 1'b1;
    if (f3 % 4 == 2 && a % 4 != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] row, input logic [2:0] f3,
                                           input logic [31:0] a);
    int sz, off;
    logic [31:0] v;
    sz  = size_of(f3);
    off = (a % 4) - ((a % 4) % sz);
    if (sz == 4) return row;
    v = (row >> (8 * off)) % (32'd1 << (8 * sz));
    if (f3 < 4 && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] row, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] wd);
    int sz, off;
    logic [31:0] mask;
    sz  = size_of(f3);
    off = (a % 4) - ((a % 4) % sz);
    if (sz == 4) return wd;
    mask = ((32'd1 << (8 * sz)) - 1) << (8 * off);
    return (row & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    reqValid = 0; reqWrite = 0; reqFunct3 = 0; reqAddr = 0; reqWData = 0;
    repeat (2) @(negedge clk);
    total++;
    if (reqReady !== 1'b1) $display("FAIL reset_ready got %b want 1", reqReady);
    else pass_cnt++;
    total++;
    if ({respValid, respErr, memReadEn, memWriteEn, respData, memReadAddr, memWriteAddr, memWriteData} !== '0)
      $display("FAIL reset_outputs got v%b e%b re%b we%b d%h ra%h wa%h wd%h want all 0",
               respValid, respErr, memReadEn, memWriteEn, respData, memReadAddr, memWriteAddr, memWriteData);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_loads();
    obs_t o;
    do_req(1'b0, 3'd0, 32'h5, 32'h0, o);
    total++;
    if (o.rd_cyc !== 1 || o.rd_addr !== 32'd1)
      $display("FAIL lb_read got cyc %0d addr %h want cyc 1 addr 1", o.rd_cyc, o.rd_addr);
    else pass_cnt++;
    total++;
    if (o.resp_cyc !== 3 || o.rdata !== 32'hFFFF_FFAA || o.rerr !== 1'b0)
      $display("FAIL lb_resp got cyc %0d data %h err %b want 3 ffffffaa 0", o.resp_cyc, o.rdata, o.rerr);
    else pass_cnt++;
    total++;
    if (o.ready_busy !== 1'b0) $display("FAIL lb_busy_ready got %b want 0", o.ready_busy);
    else pass_cnt++;
    do_req(1'b0, 3'd4, 32'h5, 32'h0, o);
    total++;
    if (o.rdata !== 32'h0000_00AA) $display("FAIL lbu_data got %h want 000000aa", o.rdata);
    else pass_cnt++;
    do_req(1'b0, 3'd5, 32'h6, 32'h0, o);
    total++;
    if (o.rdata !== 32'h0000_8899) $display("FAIL lhu_data got %h want 00008899", o.rdata);
    else pass_cnt++;
  endtask

  task automatic test_stores();
    obs_t o;
    do_req(1'b1, 3'd1, 32'h6, 32'hFFFF_1234, o);
    ref_mem[1] = 32'h1234_AABB;
    total++;
    if (o.rd_cyc !== 1 || o.wr_cyc !== 3 || o.wr_addr !== 32'd1 || o.wr_data !== 32'h1234_AABB)
      $display("FAIL sh_write got rd %0d wr %0d addr %h data %h want 1 3 1 1234aabb",
               o.rd_cyc, o.wr_cyc, o.wr_addr, o.wr_data);
    else pass_cnt++;
    total++;
    if (o.resp_cyc !== 4 || o.rdata !== 32'd0 || o.rerr !== 1'b0)
      $display("FAIL sh_resp got cyc %0d data %h err %b want 4 0 0", o.resp_cyc, o.rdata, o.rerr);
    else pass_cnt++;
    do_req(1'b0, 3'd2, 32'h4, 32'h0, o);
    total++;
    if (o.rdata !== 32'h1234_AABB) $display("FAIL lw_after_sh got %h want 1234aabb", o.rdata);
    else pass_cnt++;
    do_req(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF, o);
    ref_mem[2] = 32'hDEAD_BEEF;
    total++;
    if (o.rd_cyc !== 0 || o.wr_cyc !== 1 || o.wr_addr !== 32'd2 || o.resp_cyc !== 2 || o.rdata !== 32'd0)
      $display("FAIL sw_timing got rd %0d wr %0d addr %h resp %0d data %h want 0 1 2 2 0",
               o.rd_cyc, o.wr_cyc, o.wr_addr, o.resp_cyc, o.rdata);
    else pass_cnt++;
    do_req(1'b0, 3'd2, 32'h8, 32'h0, o);
    total++;
    if (o.rdata !== 32'hDEAD_BEEF) $display("FAIL lw_after_sw got %h want deadbeef", o.rdata);
    else pass_cnt++;
  endtask

  task automatic test_misalign_and_illegal();
    obs_t o;
    do_req(1'b0, 3'd2, 32'h6, 32'h0, o);
`ifdef MEMACC_MISALIGN_TRAP_EN
    total++;
    if (o.resp_cyc !== 1 || o.rerr !== 1'b1 || o.rd_cyc !== 0 || o.rdata !== 32'd0)
      $display("FAIL lw_misalign got resp %0d err %b rd %0d data %h want 1 1 0 0",
               o.resp_cyc, o.rerr, o.rd_cyc, o.rdata);
    else pass_cnt++;
`else
    total++;
    if (o.resp_cyc !== 3 || o.rerr !== 1'b0 || o.rd_addr !== 32'd1 || o.rdata !== 32'h1234_AABB)
      $display("FAIL lw_misalign got resp %0d err %b addr %h data %h want 3 0 1 1234aabb",
               o.resp_cyc, o.rerr, o.rd_addr, o.rdata);
    else pass_cnt++;
`endif
    do_req(1'b1, 3'd3, 32'h4, 32'hFFFF_FFFF, o);
    total++;
    if (o.resp_cyc !== 1 || o.rerr !== 1'b1 || o.rd_cyc !== 0 || o.wr_cyc !== 0 || o.rdata !== 32'd0)
      $display("FAIL store_f3_3 got resp %0d err %b rd %0d wr %0d data %h want 1 1 0 0 0",
               o.resp_cyc, o.rerr, o.rd_cyc, o.wr_cyc, o.rdata);
    else pass_cnt++;
    do_req(1'b0, 3'd6, 32'h4, 32'h0, o);
    total++;
    if (o.resp_cyc !== 1 || o.rerr !== 1'b1 || o.rd_cyc !== 0)
      $display("FAIL load_f3_6 got resp %0d err %b rd %0d want 1 1 0", o.resp_cyc, o.rerr, o.rd_cyc);
    else pass_cnt++;
  endtask

  task automatic test_rst_abort();
    int wen_seen = 0;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqFunct3 = 3'd0; reqAddr = 32'h4; reqWData = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    if (memWriteEn) wen_seen++;
    @(negedge clk);
    if (memWriteEn) wen_seen++;
    rst = 1'b0;
    #1;
    total++;
    if (reqReady !== 1'b1) $display("FAIL abort_ready got %b want 1", reqReady);
    else pass_cnt++;
    repeat (6) begin
      @(negedge clk);
      if (memWriteEn) wen_seen++;
    end
    total++;
    if (wen_seen !== 0) $display("FAIL abort_no_write got %0d write cycles want 0", wen_seen);
    else pass_cnt++;
    total++;
    if (stor[1] !== ref_mem[1]) $display("FAIL abort_row1 got %h want %h", stor[1], ref_mem[1]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    obs_t o;
    logic w, e;
    logic [2:0] f3;
    logic [31:0] a, wd, row, exp_data, exp_row;
    int e_rd, e_wr, e_resp, bad;
    bad = 0;
    for (int n = 0; n < 80; n++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom_range(0, 63);
      wd = $urandom;
      row = ref_mem[a / 4];
      e = ref_err(w, f3, a);
      exp_data = 32'd0; exp_row = row;
      if (e) begin e_rd = 0; e_wr = 0; e_resp = 1; end
      else if (!w) begin e_rd = 1; e_wr = 0; e_resp = 3; exp_data = ref_load(row, f3, a); end
      else if (f3 == 3'd2) begin e_rd = 0; e_wr = 1; e_resp = 2; exp_row = wd; end
      else begin e_rd = 1; e_wr = 3; e_resp = 4; exp_row = ref_store(row, f3, a, wd); end
      do_req(w, f3, a, wd, o);
      if (e_wr != 0) ref_mem[a / 4] = exp_row;
      total++;
      if (o.ready_idle !== 1'b1 || o.ready_busy !== 1'b0 || o.rd_cyc !== e_rd || o.wr_cyc !== e_wr ||
          o.resp_cyc !== e_resp || o.wr_cnt !== (e_wr != 0 ? 1 : 0)) begin
        $display("FAIL rnd%0d_timing w%b f3=%0d a=%h got rdy %b/%b rd %0d wr %0d(x%0d) resp %0d want 1/0 %0d %0d %0d",
                 n, w, f3, a, o.ready_idle, o.ready_busy, o.rd_cyc, o.wr_cyc, o.wr_cnt, o.resp_cyc, e_rd, e_wr, e_resp);
        bad++;
      end else pass_cnt++;
      total++;
      if (o.rdata !== exp_data || o.rerr !== e ||
          (e_rd != 0 && o.rd_addr !== a / 4) ||
          (e_wr != 0 && (o.wr_addr !== a / 4 || o.wr_data !== exp_row))) begin
        $display("FAIL rnd%0d_data w%b f3=%0d a=%h got d %h e %b ra %h wa %h wd %h want d %h e %b a %h wd %h",
                 n, w, f3, a, o.rdata, o.rerr, o.rd_addr, o.wr_addr, o.wr_data, exp_data, e, a / 4, exp_row);
        bad++;
      end else pass_cnt++;
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) if (stor[i] !== ref_mem[i]) bad++;
    total++;
    if (bad != 0) $display("FAIL rnd_final_mem got %0d mismatching rows/txns want 0", bad);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      stor[i] = $urandom;
      ref_mem[i] = stor[i];
    end
    stor[1] = 32'h8899_AABB;
    ref_mem[1] = 32'h8899_AABB;
    memReadData = 32'd0;
    test_reset();
    test_loads();
    test_stores();
    test_misalign_and_illegal();
    test_rst_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
